// File: rtl/pulse_seq.sv
// Programmable pulse-train sequencer: after a trigger, waits dly cycles, then emits
// num pulses of len high cycles separated by gap low cycles; abort cancels a running train.
module pulse_seq #(
   parameter int dly = 3,
   parameter int len = 2,
   parameter int gap = 1,
   parameter int num = 3
) (
   input  logic clk,
   input  logic rstn,
   input  logic trig,
   input  logic abort,
   output logic pulse,
   output logic busy,
   output logic done
);

   localparam int MAXP = (dly > len) ? ((dly > gap) ? dly : gap)
                                     : ((len > gap) ? len : gap);
   localparam int PW   = $clog2(MAXP + 1);
   localparam int NW   = $clog2(num + 1);

   localparam logic [PW-1:0] DLY_M1 = (dly > 0) ? PW'(dly - 1) : '0;
   localparam logic [PW-1:0] LEN_M1 = PW'(len - 1);
   localparam logic [PW-1:0] GAP_M1 = PW'(gap - 1);
   localparam logic [NW-1:0] NUM_M1 = NW'(num - 1);

   if (dly < 0 || len < 1 || gap < 1 || num < 1) begin : g_param_check
      $fatal(1, "pulse_seq: illegal parameters (need dly>=0, len>=1, gap>=1, num>=1)");
   end

   typedef enum logic [1:0] {IDLE, DELAY, HIGH, GAP} state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   cnt_q, cnt_d;
   logic [NW-1:0]   pcnt_q, pcnt_d;
   logic            trig_q, abort_q;
   logic            pulse_q, pulse_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;

   // Requests are captured first so every output is a pure register; trig is dropped
   // while a sequence is running so it can never queue a restart.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         pcnt_q  <= '0;
         trig_q  <= 1'b0;
         abort_q <= 1'b0;
         pulse_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         trig_q  <= trig & ~busy_q;
         abort_q <= abort;
         pulse_q <= pulse_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // cnt_q counts down the remaining cycles of the current phase; pcnt_q counts finished pulses.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (trig_q && !abort_q) begin
               pcnt_d = '0;
               if (dly == 0) begin
                  state_d = HIGH;
                  cnt_d   = LEN_M1;
               end else begin
                  state_d = DELAY;
                  cnt_d   = DLY_M1;
               end
            end
         end
         DELAY: begin
            if (cnt_q == '0) begin
               state_d = HIGH;
               cnt_d   = LEN_M1;
            end else begin
               cnt_d = cnt_q - PW'(1);
            end
         end
         HIGH: begin
            if (cnt_q == '0) begin
               if (pcnt_q == NUM_M1) begin
                  state_d = IDLE;
                  pcnt_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  state_d = GAP;
                  cnt_d   = GAP_M1;
                  pcnt_d  = pcnt_q + NW'(1);
               end
            end else begin
               cnt_d = cnt_q - PW'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_d = HIGH;
               cnt_d   = LEN_M1;
            end else begin
               cnt_d = cnt_q - PW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            pcnt_d  = '0;
         end
      endcase

      // Abort wins over both normal progress and completion, so no done strobe follows it.
      if (abort_q && state_q != IDLE) begin
         state_d = IDLE;
         cnt_d   = '0;
         pcnt_d  = '0;
         done_d  = 1'b0;
      end

      pulse_d = (state_d == HIGH);
      busy_d  = (state_d != IDLE);
   end

   assign pulse = pulse_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_pulse_seq.sv
// Directed bench for pulse_seq: expected pulse/busy/done per edge are generated from the
// sequence parameters when a trigger is driven, queued, and checked as the edges occur.
module tb_pulse_seq;

   localparam int HALF = 5;

   logic clk = 1'b0;
   logic rstn;
   logic trig_a, abort_a, pulse_a, busy_a, done_a;
   logic trig_b, abort_b, pulse_b, busy_b, done_b;
   logic trig_c, abort_c, pulse_c, busy_c, done_c;

   always #HALF clk = ~clk;

   pulse_seq #(.dly(3), .len(2), .gap(1), .num(3)) u_a (
      .clk(clk), .rstn(rstn), .trig(trig_a), .abort(abort_a),
      .pulse(pulse_a), .busy(busy_a), .done(done_a));

   pulse_seq #(.dly(0), .len(1), .gap(1), .num(1)) u_b (
      .clk(clk), .rstn(rstn), .trig(trig_b), .abort(abort_b),
      .pulse(pulse_b), .busy(busy_b), .done(done_b));

   pulse_seq #(.dly(8), .len(1024), .gap(3), .num(2)) u_c (
      .clk(clk), .rstn(rstn), .trig(trig_c), .abort(abort_c),
      .pulse(pulse_c), .busy(busy_c), .done(done_c));

   typedef struct {
      int          unit;
      int          at_edge;
      logic [2:0]  exp;
      string       tag;
   } sb_t;

   sb_t sb[$];
   int  edge_n = 0;
   int  tests  = 0;
   int  fails  = 0;

   function automatic void push_exp(int unit, int e, logic [2:0] exp, string tag);
      sb_t item;
      item.unit    = unit;
      item.at_edge = e;
      item.exp     = exp;
      item.tag     = tag;
      sb.push_back(item);
   endfunction

   // Expected {pulse,busy,done} from trig sampled at edge k through one idle edge after done.
   // ab >= 0 is the edge at which abort (or reset) takes hold: everything is low after it.
   function automatic void push_seq(int unit, int k, int d, int l, int g, int n, int ab, string tag);
      int t = d + n * l + (n - 1) * g;
      for (int e = k; e <= k + t + 2; e++) begin
         int   rel = e - k;
         logic p, b, dn;
         b  = (rel >= 1) && (rel <= t);
         p  = (rel >= 1 + d) && (rel <= t) && (((rel - 1 - d) % (l + g)) < l);
         dn = (rel == t + 1);
         if (ab >= 0 && e > ab) begin
            p = 1'b0; b = 1'b0; dn = 1'b0;
         end
         push_exp(unit, e, {p, b, dn}, tag);
      end
   endfunction

   function automatic void push_idle(int unit, int from, int to, string tag);
      for (int e = from; e <= to; e++) push_exp(unit, e, 3'b000, tag);
   endfunction

   task automatic check_sb();
      sb_t        e;
      logic [2:0] obs;
      while (sb.size() > 0 && sb[0].at_edge <= edge_n) begin
         e = sb.pop_front();
         case (e.unit)
            0:       obs = {pulse_a, busy_a, done_a};
            1:       obs = {pulse_b, busy_b, done_b};
            default: obs = {pulse_c, busy_c, done_c};
         endcase
         tests++;
         assert (e.at_edge == edge_n && obs === e.exp) else begin
            fails++;
            $error("FAIL %s unit%0d edge %0d: observed pbd=%b required pbd=%b",
                   e.tag, e.unit, e.at_edge, obs, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      edge_n++;
      #1;
      check_sb();
   endtask

   task automatic run_to(int e);
      while (edge_n < e) tick();
   endtask

   initial begin
      int busy_cnt, pulse_cnt, rises;
      logic pulse_prev;

      rstn    = 1'b0;
      trig_a  = 1'b1;
      abort_a = 1'b0;
      trig_b  = 1'b0;
      abort_b = 1'b0;
      trig_c  = 1'b0;
      abort_c = 1'b0;

      // Reset state, and no start from a trig that was only high during reset
      for (int e = 1; e <= 9; e++) begin
         push_exp(0, e, 3'b000, "reset_idle");
         push_exp(1, e, 3'b000, "reset_idle");
         push_exp(2, e, 3'b000, "reset_idle");
      end
      tick();
      tick();
      rstn   = 1'b1;
      trig_a = 1'b0;
      run_to(9);

      // Base timing with retrigger while busy, then back-to-back start in the done cycle
      push_seq(0, 10, 3, 2, 1, 3, -1, "base");
      trig_a = 1'b1; tick(); trig_a = 1'b0;
      tick();
      trig_a = 1'b1; run_to(21); trig_a = 1'b0;
      run_to(22);
      push_seq(0, 23, 3, 2, 1, 3, -1, "back2back");
      trig_a = 1'b1; tick(); trig_a = 1'b0;

      // Abort during the first high phase
      run_to(39);
      push_seq(0, 40, 3, 2, 1, 3, 45, "abort");
      trig_a = 1'b1; tick(); trig_a = 1'b0;
      run_to(44);
      abort_a = 1'b1; tick(); abort_a = 1'b0;

      // Abort together with trig in IDLE, then abort alone in IDLE
      run_to(54);
      push_idle(0, 55, 60, "abort_trig_idle");
      trig_a = 1'b1; abort_a = 1'b1; tick(); trig_a = 1'b0; abort_a = 1'b0;
      tick();
      abort_a = 1'b1; tick(); abort_a = 1'b0;

      // Asynchronous reset in the middle of a high phase
      run_to(61);
      push_seq(0, 62, 3, 2, 1, 3, 66, "reset_mid");
      trig_a = 1'b1; tick(); trig_a = 1'b0;
      run_to(66);
      #(HALF - 1);
      rstn = 1'b0;
      #1;
      tests++;
      assert ({pulse_a, busy_a, done_a} === 3'b000) else begin
         fails++;
         $error("FAIL async_reset_drop: observed pbd=%b required pbd=%b",
                {pulse_a, busy_a, done_a}, 3'b000);
      end
      tick();
      tick();
      rstn = 1'b1;
      push_idle(0, 76, 79, "post_reset_idle");
      run_to(79);
      push_seq(0, 80, 3, 2, 1, 3, -1, "after_reset");
      trig_a = 1'b1; tick(); trig_a = 1'b0;

      // Zero delay, single one-cycle pulse
      run_to(99);
      push_seq(1, 100, 0, 1, 1, 1, -1, "dly0");
      trig_b = 1'b1; tick(); trig_b = 1'b0;

      // Long pulses: wide phase counter
      run_to(109);
      push_seq(2, 110, 8, 1024, 3, 2, -1, "long");
      trig_c = 1'b1; tick(); trig_c = 1'b0;
      busy_cnt   = 0;
      pulse_cnt  = 0;
      rises      = 0;
      pulse_prev = pulse_c;
      while (edge_n < 2175) begin
         tick();
         if (busy_c)  busy_cnt++;
         if (pulse_c) pulse_cnt++;
         if (pulse_c && !pulse_prev) rises++;
         pulse_prev = pulse_c;
      end
      tests++;
      assert (busy_cnt == 2059) else begin
         fails++;
         $error("FAIL long_busy_cycles: observed %0d required %0d", busy_cnt, 2059);
      end
      tests++;
      assert (pulse_cnt == 2048) else begin
         fails++;
         $error("FAIL long_pulse_cycles: observed %0d required %0d", pulse_cnt, 2048);
      end
      tests++;
      assert (rises == 2) else begin
         fails++;
         $error("FAIL long_pulse_count: observed %0d required %0d", rises, 2);
      end

      tests++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL scoreboard_drain: observed %0d left required %0d", sb.size(), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pulse_seq.md
PULSE_SEQ -- requirements
Module: pulse_seq

Interface
REQ-001 SHALL have parameter dly, default 3: idle cycles between trigger acceptance and first pulse rise (legal >= 0).
REQ-002 SHALL have parameter len, default 2: high cycles per pulse (legal >= 1).
REQ-003 SHALL have parameter gap, default 1: low cycles between consecutive pulses (legal >= 1).
REQ-004 SHALL have parameter num, default 3: pulses per sequence (legal >= 1).
REQ-005 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port trig  input  1  start request, sampled on posedge clk, clk-domain single-cycle strobe (e.g. opulse of an upstream clock-crossing stage).
REQ-008 SHALL have port abort  input  1  synchronous cancel of a running sequence.
REQ-009 SHALL have port pulse  output  1  registered pulse-train output.
REQ-010 SHALL have port busy  output  1  registered, high while a sequence is in progress.
REQ-011 SHALL have port done  output  1  registered, one-cycle strobe on normal sequence completion.

Function
REQ-012 SHALL implement FSM states IDLE, DELAY, HIGH, GAP; all outputs registered, no combinational input-to-output path.
REQ-013 SHALL, in IDLE with trig=1 and abort=0 sampled at edge k, set busy=1 at edge k+1 and raise pulse at edge k+1+dly.
REQ-014 SHALL, when dly=0, go IDLE->HIGH directly (pulse and busy both rise at edge k+1); otherwise occupy DELAY for exactly dly cycles.
REQ-015 SHALL hold pulse high exactly len cycles per pulse, then low exactly gap cycles before the next pulse.
REQ-016 SHALL, at the edge ending the num-th high phase, drive pulse=0, busy=0, done=1 and return to IDLE; no trailing gap after the last pulse.
REQ-017 SHALL keep done high exactly one cycle; done=0 at all other times.
REQ-018 SHALL ignore trig while busy=1 (no queuing, no restart, no extension).
REQ-019 SHALL accept trig sampled in the cycle where done=1 (state already IDLE), giving back-to-back sequences.
REQ-020 SHALL, on abort=1 sampled while busy=1, at the next edge force pulse=0, busy=0, done=0 and return to IDLE.
REQ-021 SHALL give abort priority over trig when both are sampled high in IDLE: no sequence starts.
REQ-022 SHALL treat abort in IDLE as a no-op.
REQ-023 SHALL size the phase counter to $clog2(max(dly,len,gap)+1) bits and the pulse counter to $clog2(num+1) bits; counters never wrap within a sequence.
REQ-024 SHALL fail elaboration if len<1, gap<1 or num<1.
REQ-025 SHALL produce total busy duration of dly + num*len + (num-1)*gap cycles per uninterrupted sequence.

Reset
REQ-026 SHALL, while rstn=0, asynchronously force state=IDLE, pulse=0, busy=0, done=0, all counters=0.
REQ-027 SHALL, on rstn assertion mid-sequence, abandon the sequence immediately with no done strobe; after deassertion wait for a fresh trig.
REQ-028 SHALL not start a sequence on trig sampled at the first edge after rstn deassertion unless trig is genuinely high at that edge (no spurious start from reset).

Verification
REQ-029 SHALL verify dly=3,len=2,gap=1,num=3, trig sampled edge 10 -> busy high after edges 11..21, pulse high after edges 14,15,17,18,20,21, done=1 only after edge 22.
REQ-030 SHALL verify dly=0,len=1,gap=1,num=1, trig at edge 5 -> pulse and busy high after edge 6 only, done after edge 7.
REQ-031 SHALL verify trig re-asserted at edges 12..21 of REQ-029 run -> waveform identical to REQ-029; trig at edge 23 (done cycle) -> pulse rises edge 27.
REQ-032 SHALL verify abort sampled at edge 15 of REQ-029 run -> after edge 16 pulse=0, busy=0, done never asserts; abort+trig together in IDLE -> busy stays 0.
REQ-033 SHALL verify rstn low asynchronously at mid-cycle during HIGH -> pulse, busy, done drop to 0 immediately; next trig after release reproduces REQ-029 timing.
REQ-034 SHALL verify dly=8,len=1024,gap=3,num=2 -> each high phase exactly 1024 cycles, gap exactly 3, busy exactly 2059 cycles.
